cvxif_result_buffer: RTL and testbench

//  Buffers CV-X-IF coprocessor result transactions and delivers them, in order, to the scoreboard writeback port.

---
 rtl/cvxif_result_buffer.sv | 112 +++++++++++
 tb/tb_cvxif_result_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_result_buffer.sv
// In-order buffer for CV-X-IF coprocessor results, feeding the scoreboard writeback port.
// The head entry is presented from registers. A flush discards every pending result.
module cvxif_result_buffer #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NR_SB_ENTRIES = 8,
    parameter int unsigned DEPTH         = 4,
    localparam int unsigned TRANS_ID_W   = $clog2(NR_SB_ENTRIES),
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  x_result_valid_i,
    output logic                  x_result_ready_o,
    input  logic [TRANS_ID_W-1:0] x_result_id_i,
    input  logic [XLEN-1:0]       x_result_data_i,
    input  logic                  x_result_we_i,
    input  logic                  x_result_exc_i,
    input  logic [5:0]            x_result_exccode_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [TRANS_ID_W-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  wb_we_o,
    output logic                  wb_exc_valid_o,
    output logic [5:0]            wb_exc_cause_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [TRANS_ID_W-1:0] id_q      [DEPTH];
    logic [XLEN-1:0]       data_q    [DEPTH];
    logic                  we_q      [DEPTH];
    logic                  exc_q     [DEPTH];
    logic [5:0]            exccode_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic head_valid;
    logic push;
    logic pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds valid and payload stable until accepted.
    // Popping the head frees a slot, so a full buffer still accepts in that cycle.
    assign head_valid       = (count_q != '0);
    assign pop              = head_valid & wb_ready_i;
    assign x_result_ready_o = rst_ni & ~flush_i & ((count_q < DEPTH_C) | pop);
    assign push             = x_result_valid_i & x_result_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: nothing is visible until count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr_q]      <= x_result_id_i;
            data_q[wr_ptr_q]    <= x_result_data_i;
            we_q[wr_ptr_q]      <= x_result_we_i;
            exc_q[wr_ptr_q]     <= x_result_exc_i;
            exccode_q[wr_ptr_q] <= x_result_exccode_i;
        end
    end

    // An excepting entry never writes rd and carries no data.
    always_comb begin
        wb_valid_o     = head_valid;
        wb_trans_id_o  = '0;
        wb_data_o      = '0;
        wb_we_o        = 1'b0;
        wb_exc_valid_o = 1'b0;
        wb_exc_cause_o = '0;
        if (head_valid) begin
            wb_trans_id_o  = id_q[rd_ptr_q];
            wb_exc_valid_o = exc_q[rd_ptr_q];
            if (exc_q[rd_ptr_q]) begin
                wb_exc_cause_o = exccode_q[rd_ptr_q];
            end else begin
                wb_data_o = data_q[rd_ptr_q];
                wb_we_o   = we_q[rd_ptr_q];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Self-checking bench for cvxif_result_buffer: directed scenarios plus a random
// valid/ready run, with a negedge scoreboard comparing every writeback against pushes.
module tb_cvxif_result_buffer;

    localparam int W = 43;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        x_result_valid_i;
    logic        x_result_ready_o;
    logic [2:0]  x_result_id_i;
    logic [31:0] x_result_data_i;
    logic        x_result_we_i;
    logic        x_result_exc_i;
    logic [5:0]  x_result_exccode_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [2:0]  wb_trans_id_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic        wb_exc_valid_o;
    logic [5:0]  wb_exc_cause_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    cvxif_result_buffer dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .x_result_valid_i   (x_result_valid_i),
        .x_result_ready_o   (x_result_ready_o),
        .x_result_id_i      (x_result_id_i),
        .x_result_data_i    (x_result_data_i),
        .x_result_we_i      (x_result_we_i),
        .x_result_exc_i     (x_result_exc_i),
        .x_result_exccode_i (x_result_exccode_i),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_trans_id_o      (wb_trans_id_o),
        .wb_data_o          (wb_data_o),
        .wb_we_o            (wb_we_o),
        .wb_exc_valid_o     (wb_exc_valid_o),
        .wb_exc_cause_o     (wb_exc_cause_o),
        .count_o            (count_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_ni             = 1'b0;
        flush_i            = 1'b0;
        x_result_valid_i   = 1'b0;
        x_result_id_i      = '0;
        x_result_data_i    = '0;
        x_result_we_i      = 1'b0;
        x_result_exc_i     = 1'b0;
        x_result_exccode_i = '0;
        wb_ready_i         = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // scoreboard: sampled mid-cycle, when inputs and outputs are settled for the next edge
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] exp_v;
        if (rst_ni !== 1'b1) begin
            exp_q.delete();
        end else if (mon_en) begin
            obs = {wb_exc_valid_o, wb_exc_cause_o, wb_we_o, wb_data_o, wb_trans_id_o};
            checks++;
            if (count_o > 3'd4 || int'(count_o) != exp_q.size()) begin
                errors++;
                $display("FAIL occupancy: count_o=%0d expected=%0d", count_o, exp_q.size());
            end
            if (count_o == 3'd0) begin
                checks++;
                if (obs !== '0 || wb_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL empty_outputs: got valid=%b fields=%h expected 0", wb_valid_o, obs);
                end
            end
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (wb_valid_o && wb_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL writeback_order: unexpected entry %h, expected none", obs);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (obs !== exp_v) begin
                            errors++;
                            $display("FAIL writeback_order: got %h expected %h", obs, exp_v);
                        end
                    end
                end
                if (x_result_valid_i && x_result_ready_o) begin
                    exp_q.push_back({x_result_exc_i,
                                     x_result_exc_i ? x_result_exccode_i : 6'd0,
                                     x_result_exc_i ? 1'b0 : x_result_we_i,
                                     x_result_exc_i ? 32'd0 : x_result_data_i,
                                     x_result_id_i});
                end
            end
        end
    end

    // driver tasks
    task automatic push_one(input logic [2:0] id, input logic [31:0] data,
                            input logic we, input logic exc, input logic [5:0] code);
        logic accepted;
        accepted           = 1'b0;
        x_result_id_i      = id;
        x_result_data_i    = data;
        x_result_we_i      = we;
        x_result_exc_i     = exc;
        x_result_exccode_i = code;
        x_result_valid_i   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (x_result_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL push_timeout: id=%0d not accepted, ready=%b expected 1", id, x_result_ready_o);
        end
        @(posedge clk);
        #1;
        x_result_valid_i = 1'b0;
    endtask

    task automatic drain();
        wb_ready_i = 1'b1;
        for (int t = 0; t < 200 && count_o != 3'd0; t++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout: count_o=%0d expected 0", count_o);
        end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni           = 1'b0;
        x_result_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (x_result_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", x_result_ready_o);
        end
        checks++;
        if (wb_valid_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: wb_valid=%b count=%0d expected 0/0", wb_valid_o, count_o);
        end
        rst_ni           = 1'b1;
        x_result_valid_i = 1'b0;
        #1;
        checks++;
        if (x_result_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", x_result_ready_o);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        wb_ready_i = 1'b0;
        push_one(3'd3, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd3 || wb_data_o !== 32'hDEADBEEF ||
            wb_we_o !== 1'b1 || count_o !== 3'd1) begin
            errors++;
            $display("FAIL single_push: valid=%b id=%0d data=%h we=%b count=%0d expected 1/3/deadbeef/1/1",
                     wb_valid_o, wb_trans_id_o, wb_data_o, wb_we_o, count_o);
        end
        drain();
    endtask

    task automatic test_full();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(3'(i), 32'h1000 + 32'(i), 1'b1, 1'b0, 6'd0);
        end
        x_result_valid_i = 1'b1;
        x_result_id_i    = 3'd4;
        x_result_data_i  = 32'h1004;
        #1;
        checks++;
        if (count_o !== 3'd4 || x_result_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d ready=%b expected 4/0", count_o, x_result_ready_o);
        end
        wb_ready_i = 1'b1;
        #1;
        checks++;
        if (x_result_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_ready: got %b expected 1", x_result_ready_o);
        end
        push_one(3'd4, 32'h1004, 1'b1, 1'b0, 6'd0);
        checks++;
        if (count_o !== 3'd4 || wb_trans_id_o !== 3'd1) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d head=%0d expected 4/1", count_o, wb_trans_id_o);
        end
        drain();
    endtask

    task automatic test_exception();
        wb_ready_i = 1'b0;
        push_one(3'd5, 32'h1234, 1'b1, 1'b1, 6'd2);
        checks++;
        if (wb_exc_valid_o !== 1'b1 || wb_exc_cause_o !== 6'd2 || wb_we_o !== 1'b0 ||
            wb_data_o !== 32'd0 || wb_trans_id_o !== 3'd5) begin
            errors++;
            $display("FAIL exception: exc=%b cause=%0d we=%b data=%h id=%0d expected 1/2/0/0/5",
                     wb_exc_valid_o, wb_exc_cause_o, wb_we_o, wb_data_o, wb_trans_id_o);
        end
        drain();
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        push_one(3'd5, 32'hA5, 1'b1, 1'b0, 6'd0);
        push_one(3'd6, 32'hA6, 1'b0, 1'b0, 6'd0);
        push_one(3'd7, 32'hA7, 1'b1, 1'b0, 6'd0);
        checks++;
        if (count_o !== 3'd3) begin
            errors++;
            $display("FAIL flush_prefill: count=%0d expected 3", count_o);
        end
        flush_i          = 1'b1;
        wb_ready_i       = 1'b1;
        x_result_valid_i = 1'b1;
        x_result_id_i    = 3'd1;
        x_result_data_i  = 32'hBAD;
        #1;
        checks++;
        if (x_result_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0", x_result_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i          = 1'b0;
        x_result_valid_i = 1'b0;
        wb_ready_i       = 1'b0;
        checks++;
        if (count_o !== 3'd0 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d valid=%b expected 0/0", count_o, wb_valid_o);
        end
        push_one(3'd2, 32'hC2, 1'b1, 1'b0, 6'd0);
        checks++;
        if (wb_trans_id_o !== 3'd2 || count_o !== 3'd1) begin
            errors++;
            $display("FAIL flush_after: head=%0d count=%0d expected 2/1", wb_trans_id_o, count_o);
        end
        drain();
    endtask

    task automatic test_random_stall();
        logic acc;
        x_result_valid_i = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = x_result_valid_i & x_result_ready_o;
            @(posedge clk);
            #1;
            if (acc || !x_result_valid_i) begin
                x_result_valid_i   = ($urandom_range(0, 99) < 60);
                x_result_id_i      = 3'($urandom_range(0, 7));
                x_result_data_i    = $urandom;
                x_result_we_i      = 1'($urandom_range(0, 1));
                x_result_exc_i     = ($urandom_range(0, 7) == 0);
                x_result_exccode_i = 6'($urandom_range(0, 63));
            end
            wb_ready_i = ($urandom_range(0, 99) < 50);
        end
        x_result_valid_i = 1'b0;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_leftover: %0d entries expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_exception();
        test_flush();
        test_random_stall();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
